// File: rtl/node_sched_pkg.sv
// Shared types, widths and result formatting for the dense-layer MAC scheduler.
// Build option: NODE_SCHED_SAT_EN selects saturating truncation of the result.
package node_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam int DATA_W = 32;
    localparam int RES_W  = 16;

    // ReLU followed by a Q-format window of RES_W bits starting at bit 'frac'.
    function automatic logic [RES_W-1:0] relu_trunc(input logic [DATA_W-1:0] acc,
                                                    input int               frac);
        logic [DATA_W-1:0] shifted;
        shifted = acc >> frac;
        if (acc[DATA_W-1]) begin
            return '0;
        end
`ifdef NODE_SCHED_SAT_EN
        // Any magnitude bit above the result window means the value does not fit.
        if ((acc[DATA_W-2:0] >> (frac + RES_W)) != '0) begin
            return '1;
        end
`endif
        return shifted[RES_W-1:0];
    endfunction

endpackage

// File: rtl/node_mac_unit.sv
// Registered 32-bit multiply-accumulate with clear, product-enable and bias-add.
// acc_sum is the value the accumulator takes on the next enabled edge, so the
// scheduler can format the final result in the same cycle the bias lands.
module node_mac_unit
    import node_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              acc_en,
    input  logic              bias_en,
    input  logic [DATA_W-1:0] act,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] bias,
    output logic [DATA_W-1:0] acc_sum
);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] product;

    // Low word of a two's-complement product is independent of signedness.
    assign product = act * weight;

    // Next accumulator value; wraps modulo 2^32.
    always_comb begin
        acc_sum = acc;
        if (acc_en) begin
            acc_sum = acc_sum + product;
        end
        if (bias_en) begin
            acc_sum = acc_sum + bias;
        end
    end

    // Accumulator register; clear wins over accumulate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (acc_en || bias_en) begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/node_mac_scheduler.sv
// Time-multiplexes one MAC datapath over all N_OUT neurons of a dense layer.
// Build option: NODE_SCHED_SAT_EN (see node_sched_pkg::relu_trunc).
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | waiting for start; busy low
// MAC   | issuing act/weight address k = 0..N_IN-1 for neuron j
// DRAIN | last product on the data bus; accumulate it plus bias, format result
// FIN   | out_valid held with stable index/data until out_ready
module node_mac_scheduler
    import node_sched_pkg::*;
#(
    parameter int N_IN  = 15,
    parameter int N_OUT = 16,
    parameter int FRAC  = 13,
    parameter int AW    = 4,
    parameter int WW    = 8,
    parameter int OW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     act_addr,
    input  logic [DATA_W-1:0] act_data,
    output logic [WW-1:0]     w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [OW-1:0]     b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     out_idx,
    output logic [DATA_W-1:0] out_data
);

    state_t            state;
    logic              accept;
    logic              handshake;
    logic              last_neuron;
    logic              acc_clear;
    logic              acc_en;
    logic              bias_en;
    logic [DATA_W-1:0] acc_sum;

    // A start coinciding with the done pulse is dropped so a pass cannot be
    // relaunched by a start that was really aimed at the previous one.
    assign accept      = (state == IDLE) && start && !done;
    assign handshake   = (state == FIN) && out_ready;
    assign last_neuron = (b_addr == OW'(N_OUT - 1));
    assign acc_clear   = accept || (handshake && !last_neuron);

    // Read data trails its address by one cycle: while act_addr = k the bus
    // carries k-1, and DRAIN carries the final pair.
    assign acc_en  = ((state == MAC) && (act_addr != '0)) || (state == DRAIN);
    assign bias_en = (state == DRAIN);

    node_mac_unit u_mac (
        .clk     (clk),
        .reset   (reset),
        .clear   (acc_clear),
        .acc_en  (acc_en),
        .bias_en (bias_en),
        .act     (act_data),
        .weight  (w_data),
        .bias    (b_data),
        .acc_sum (acc_sum)
    );

    // Sequencer: state, address counters and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            act_addr  <= '0;
            w_addr    <= '0;
            b_addr    <= '0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= MAC;
                        busy     <= 1'b1;
                        act_addr <= '0;
                        w_addr   <= '0;
                        b_addr   <= '0;
                    end
                end
                MAC: begin
                    if (act_addr == AW'(N_IN - 1)) begin
                        state <= DRAIN;
                    end else begin
                        act_addr <= act_addr + AW'(1);
                        w_addr   <= w_addr + WW'(1);
                    end
                end
                DRAIN: begin
                    state     <= FIN;
                    out_valid <= 1'b1;
                    out_idx   <= b_addr;
                    out_data  <= {{(DATA_W - RES_W){1'b0}}, relu_trunc(acc_sum, FRAC)};
                end
                FIN: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (last_neuron) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // Weight rows are contiguous, so the next row starts one past this one.
                            state    <= MAC;
                            act_addr <= '0;
                            w_addr   <= w_addr + WW'(1);
                            b_addr   <= b_addr + OW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_node_mac_scheduler.sv
// Self-checking bench for node_mac_scheduler: behavioural dot-product model,
// memories with one-cycle read latency, randomized data and back-pressure.
module tb_node_mac_scheduler;

    localparam int N_IN  = 15;
    localparam int N_OUT = 16;
    localparam int FRAC  = 13;
    localparam int AW    = 4;
    localparam int WW    = 8;
    localparam int OW    = 4;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] act_addr;
    logic [31:0]   act_data;
    logic [WW-1:0] w_addr;
    logic [31:0]   w_data;
    logic [OW-1:0] b_addr;
    logic [31:0]   b_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_idx;
    logic [31:0]   out_data;

    int act_mem [N_IN];
    int w_mem   [N_IN*N_OUT];
    int b_mem   [N_OUT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    node_mac_scheduler #(
        .N_IN (N_IN), .N_OUT(N_OUT), .FRAC(FRAC), .AW(AW), .WW(WW), .OW(OW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .act_addr  (act_addr),
        .act_data  (act_data),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clk) begin
        act_data <= act_mem[act_addr];
        w_data   <= w_mem[w_addr];
        b_data   <= b_mem[b_addr];
    end

    // Reference: dot product + bias with 32-bit wrap, then ReLU and Q window.
    function automatic logic [15:0] expect_res(input int j);
        int acc;
        acc = 0;
        for (int k = 0; k < N_IN; k++) acc = acc + act_mem[k] * w_mem[j*N_IN + k];
        acc = acc + b_mem[j];
        if (acc < 0) return 16'h0000;
`ifdef NODE_SCHED_SAT_EN
        if ((acc >>> (FRAC + 16)) != 0) return 16'hFFFF;
`endif
        return 16'(acc >>> FRAC);
    endfunction

    task automatic fill(input int act_v, input int w_v, input int b_v);
        for (int k = 0; k < N_IN; k++) act_mem[k] = act_v;
        for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = w_v;
        for (int j = 0; j < N_OUT; j++) b_mem[j] = b_v;
    endtask

    task automatic fill_random(input bit full_range);
        for (int k = 0; k < N_IN; k++)
            act_mem[k] = full_range ? int'($urandom()) : int'($urandom_range(0, 65535));
        for (int i = 0; i < N_IN*N_OUT; i++)
            w_mem[i] = full_range ? int'($urandom()) : int'($urandom_range(0, 32767)) - 16384;
        for (int j = 0; j < N_OUT; j++)
            b_mem[j] = int'($urandom_range(0, 200000)) - 100000;
    endtask

    // One layer pass; optional random ready, a 5-cycle stall at stall_j, or a
    // reset abort once neuron abort_j presents its result.
    task automatic run_layer(input bit rand_ready, input int stall_j, input int abort_j);
        int j, c_s, wait_cyc, stall_left;
        bit seen;
        logic [31:0]   hold_data;
        logic [OW-1:0] hold_idx;
        logic [WW-1:0] hold_w;
        j = 0; seen = 0; wait_cyc = 0; stall_left = 5;
        hold_data = '0; hold_idx = '0; hold_w = '0;
        start = 1'b1; out_ready = 1'b1; c_s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_start got %b want 1", busy);
        end
        while (j < N_OUT) begin
            if (wait_cyc > 200) begin
                checks++; errors++; start = 1'b0;
                $display("FAIL timeout neuron %0d waited %0d cycles limit 200", j, wait_cyc);
                return;
            end
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            else            out_ready = !(j == stall_j && stall_left > 0);
            start = (j == stall_j) && (wait_cyc == 4 || stall_left == 2);
            if (out_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1; hold_data = out_data; hold_idx = out_idx; hold_w = w_addr;
                    checks++;
                    if (out_idx !== OW'(j)) begin
                        errors++; $display("FAIL out_idx got %0d want %0d", out_idx, j);
                    end
                    checks++;
                    if (out_data !== {16'h0, expect_res(j)}) begin
                        errors++; $display("FAIL out_data neuron %0d got %h want %h", j, out_data, {16'h0, expect_res(j)});
                    end
                    if (!rand_ready && (stall_j < 0 || j <= stall_j)) begin
                        checks++;
                        if (cyc - c_s != (j + 1) * (N_IN + 2)) begin
                            errors++; $display("FAIL latency neuron %0d got %0d want %0d", j, cyc - c_s, (j + 1) * (N_IN + 2));
                        end
                    end
                    if (j == abort_j) begin
                        reset = 1'b0;
                        #1;
                        checks++;
                        if ({busy, done, out_valid} !== 3'b000 || out_data !== '0 || out_idx !== '0 ||
                            act_addr !== '0 || w_addr !== '0 || b_addr !== '0) begin
                            errors++;
                            $display("FAIL abort_outputs got busy=%b done=%b valid=%b data=%h idx=%0d a=%0d w=%0d b=%0d want all 0",
                                     busy, done, out_valid, out_data, out_idx, act_addr, w_addr, b_addr);
                        end
                        start = 1'b0; out_ready = 1'b1;
                        #2 reset = 1'b1;
                        return;
                    end
                end else begin
                    checks++;
                    if (out_data !== hold_data || out_idx !== hold_idx || w_addr !== hold_w) begin
                        errors++;
                        $display("FAIL hold_stable got data=%h idx=%0d w=%0d want data=%h idx=%0d w=%0d",
                                 out_data, out_idx, w_addr, hold_data, hold_idx, hold_w);
                    end
                end
                if (j == stall_j && stall_left > 0) stall_left--;
                if (out_ready) begin
                    j++; seen = 0; wait_cyc = 0;
                end
            end
            @(posedge clk); #1;
            wait_cyc++;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL done_pulse got done=%b busy=%b valid=%b want 1 0 0", done, busy, out_valid);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL start_on_done got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, out_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {busy, done, out_valid});
        end
        checks++;
        if (act_addr !== '0 || w_addr !== '0 || b_addr !== '0) begin
            errors++; $display("FAIL reset_addr got a=%0d w=%0d b=%0d want 0", act_addr, w_addr, b_addr);
        end
        checks++;
        if (out_idx !== '0 || out_data !== '0) begin
            errors++; $display("FAIL reset_out got idx=%0d data=%h want 0", out_idx, out_data);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset busy got %b want 0", busy);
        end
    endtask

    task automatic test_defaults;
        fill(1, 8192, 0);
        run_layer(1'b0, -1, -1);
    endtask

    task automatic test_relu;
        fill(1, -8192, 315);
        run_layer(1'b0, -1, -1);
    endtask

    task automatic test_q_format;
        fill(0, 8192, 0);
        act_mem[0] = 32768;
        run_layer(1'b0, -1, -1);
        act_mem[0] = 65536;
        run_layer(1'b0, -1, -1);
    endtask

    task automatic test_random;
        fill_random(1'b0);
        run_layer(1'b1, -1, -1);
        fill_random(1'b1);
        run_layer(1'b1, -1, -1);
    endtask

    task automatic test_stall;
        fill_random(1'b0);
        run_layer(1'b0, 3, -1);
    endtask

    task automatic test_reset_mid_pass;
        fill_random(1'b0);
        run_layer(1'b0, -1, 7);
        @(posedge clk); #1;
        run_layer(1'b0, -1, -1);
    endtask

    initial begin
        for (int k = 0; k < N_IN; k++) act_mem[k] = 0;
        for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = 0;
        for (int j = 0; j < N_OUT; j++) b_mem[j] = 0;
        test_reset;
        test_defaults;
        test_relu;
        test_q_format;
        test_random;
        test_stall;
        test_reset_mid_pass;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d limit 200000", cyc);
        $fatal(1, "watchdog");
    end

endmodule
